// File: rtl/mmio_pkg.sv
// Shared types for the MMIO bus initiator: FSM states, latched request and held response.
package mmio_pkg;

  localparam int TAG_MAX_W = 8;
  localparam logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic                 we;
    logic [31:0]          addr;
    logic [3:0]           wmask;
    logic [31:0]          wdata;
    logic [TAG_MAX_W-1:0] tag;
  } MmioReq_t;

  typedef struct packed {
    logic [31:0]          data;
    logic                 err;
    logic [TAG_MAX_W-1:0] tag;
  } MmioResp_t;

endpackage

// File: rtl/mmio_initiator.sv
// Single-outstanding MMIO bus initiator; optional rvalid timeout under MMIO_TIMEOUT_EN.
// Latency: read accept->resp 3 cycles min, write 2, misaligned 1.
// Backpressure: rbusy holds the strobe cycle; resp held stable until resp_ready, req_ready only in IDLE.
module mmio_initiator
  import mmio_pkg::*;
#(
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IN_req_valid,
  output logic             OUT_req_ready,
  input  logic             IN_req_we,
  input  logic [31:0]      IN_req_addr,
  input  logic [3:0]       IN_req_wmask,
  input  logic [31:0]      IN_req_wdata,
  input  logic [TAG_W-1:0] IN_req_tag,
  output logic             OUT_resp_valid,
  input  logic             IN_resp_ready,
  output logic [31:0]      OUT_resp_data,
  output logic             OUT_resp_err,
  output logic [TAG_W-1:0] OUT_resp_tag,
  output logic             OUT_re,
  output logic [29:0]      OUT_raddr,
  input  logic [31:0]      IN_rdata,
  input  logic             IN_rbusy,
  input  logic             IN_rvalid,
  output logic             OUT_we,
  output logic [3:0]       OUT_wmask,
  output logic [29:0]      OUT_waddr,
  output logic [31:0]      OUT_wdata
);

  state_t    state, state_nxt;
  MmioReq_t  req, in_req;
  MmioResp_t resp;
  logic      re, we, resp_valid;
  logic      accept, misaligned, req_we_nxt, timeout;

  assign in_req = '{we:    IN_req_we,
                    addr:  IN_req_addr,
                    wmask: IN_req_wmask,
                    wdata: IN_req_wdata,
                    tag:   TAG_MAX_W'(IN_req_tag)};

  assign OUT_req_ready = (state == IDLE) && rst;
  assign accept        = IN_req_valid && OUT_req_ready;
  assign misaligned    = (in_req.addr[1:0] != 2'b00);
  assign req_we_nxt    = accept ? in_req.we : req.we;

`ifdef MMIO_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] tmo_cnt;

  // Counts WAIT_R cycles; value N means this is the (N+1)th cycle spent waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (state != WAIT_R && state_nxt == WAIT_R) begin
      tmo_cnt <= '0;
    end else if (state == WAIT_R) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign timeout = (state == WAIT_R) && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = misaligned ? RESP : ISSUE;
      ISSUE:   if (!IN_rbusy) state_nxt = req.we ? RESP : WAIT_R;
      WAIT_R:  if (IN_rvalid || timeout) state_nxt = RESP;
      RESP:    if (IN_resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      req        <= '0;
      resp       <= '0;
      re         <= 1'b0;
      we         <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      re         <= (state_nxt == ISSUE) && !req_we_nxt;
      we         <= (state_nxt == ISSUE) &&  req_we_nxt;
      resp_valid <= (state_nxt == RESP);
      if (accept) begin
        req       <= in_req;
        resp.tag  <= in_req.tag;
        resp.data <= '0;
        resp.err  <= misaligned;
      end
      // rvalid takes priority over a timeout landing in the same cycle.
      if (state == WAIT_R && IN_rvalid) begin
        resp.data <= IN_rdata;
        resp.err  <= 1'b0;
      end else if (timeout) begin
        resp.data <= TIMEOUT_DATA;
        resp.err  <= 1'b1;
      end
    end
  end

  assign OUT_re         = re;
  assign OUT_we         = we;
  assign OUT_raddr      = req.addr[31:2];
  assign OUT_waddr      = req.addr[31:2];
  assign OUT_wmask      = req.wmask;
  assign OUT_wdata      = req.wdata;
  assign OUT_resp_valid = resp_valid;
  assign OUT_resp_data  = resp.data;
  assign OUT_resp_err   = resp.err;
  assign OUT_resp_tag   = resp.tag[TAG_W-1:0];

  logic unused_bits;
  assign unused_bits = ^{req.tag, req.addr[1:0], resp.tag};

  a_one_strobe: assert property (@(posedge clk) disable iff (!rst) !(re && we));

endmodule

// File: tb/tb_mmio_initiator.sv
// Directed-vector bench for mmio_initiator; the timeout section builds only with MMIO_TIMEOUT_EN.
module tb_mmio_initiator;

  localparam int TAG_W       = 4;
  localparam int TIMEOUT_CYC = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_we = 1'b0;
  logic [31:0]      req_addr = '0;
  logic [3:0]       req_wmask = '0;
  logic [31:0]      req_wdata = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b1;
  logic [31:0]      resp_data;
  logic             resp_err;
  logic [TAG_W-1:0] resp_tag;
  logic             re;
  logic [29:0]      raddr;
  logic [31:0]      rdata = '0;
  logic             rbusy = 1'b0;
  logic             rvalid = 1'b0;
  logic             we;
  logic [3:0]       wmask;
  logic [29:0]      waddr;
  logic [31:0]      wdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mmio_initiator #(.TAG_W(TAG_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst),
    .IN_req_valid(req_valid), .OUT_req_ready(req_ready),
    .IN_req_we(req_we), .IN_req_addr(req_addr), .IN_req_wmask(req_wmask),
    .IN_req_wdata(req_wdata), .IN_req_tag(req_tag),
    .OUT_resp_valid(resp_valid), .IN_resp_ready(resp_ready),
    .OUT_resp_data(resp_data), .OUT_resp_err(resp_err), .OUT_resp_tag(resp_tag),
    .OUT_re(re), .OUT_raddr(raddr), .IN_rdata(rdata), .IN_rbusy(rbusy),
    .IN_rvalid(rvalid), .OUT_we(we), .OUT_wmask(wmask), .OUT_waddr(waddr),
    .OUT_wdata(wdata)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Presents one request for a single cycle; returns at the negedge of cycle 1.
  task automatic send_req(input logic w, input logic [31:0] a, input logic [3:0] m,
                          input logic [31:0] d, input logic [TAG_W-1:0] t);
    req_valid = 1'b1;
    req_we    = w;
    req_addr  = a;
    req_wmask = m;
    req_wdata = d;
    req_tag   = t;
    check("req_ready_idle", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(); tick();
    check("rst_ready", req_ready, 0);
    check("rst_strobes", {re, we, resp_valid, resp_err}, 4'b0000);
    check("rst_data", {raddr, waddr, wmask, wdata, resp_data, resp_tag}, '0);
    rst = 1'b1;
    tick();
    check("ready_after_rst", req_ready, 1);

    // aligned write, no busy
    send_req(1'b1, 32'hFF00_0004, 4'b0001, 32'h0000_0055, 4'h3);
    check("wr_strobe_c1", {we, re, resp_valid}, 3'b100);
    check("wr_bus_c1", {waddr, wmask, wdata}, {30'h3FC0_0001, 4'b0001, 32'h0000_0055});
    check("wr_ready_busy", req_ready, 0);
    tick();
    check("wr_resp_c2", {we, resp_valid, resp_err, resp_data, resp_tag},
          {1'b0, 1'b1, 1'b0, 32'h0, 4'h3});
    tick();
    check("wr_back_idle", {resp_valid, req_ready}, 2'b01);

    // aligned read, rvalid one cycle after re
    send_req(1'b0, 32'h1000_0000, 4'h0, 32'h0, 4'h5);
    check("rd_strobe_c1", {re, we, raddr}, {1'b1, 1'b0, 30'h0400_0000});
    tick();
    check("rd_c2", {re, resp_valid}, 2'b00);
    rvalid = 1'b1;
    rdata  = 32'hDEAD_BEEF;
    tick();
    rvalid = 1'b0;
    rdata  = 32'h0;
    check("rd_resp_c3", {re, resp_valid, resp_err, resp_data, resp_tag},
          {1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'h5});
    tick();

    // read held by rbusy for 3 cycles, stray rvalid in the ISSUE cycle ignored
    rbusy = 1'b1;
    send_req(1'b0, 32'h2000_0010, 4'hF, 32'h0, 4'h6);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("busy_hold_%0d", i), {re, we, raddr}, {1'b1, 1'b0, 30'h0800_0004});
      if (i == 3) begin
        rbusy  = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'hBAD0_BAD0;
      end
      tick();
    end
    rvalid = 1'b0;
    check("busy_wait1", {re, resp_valid}, 2'b00);
    tick();
    check("busy_wait2", {re, resp_valid}, 2'b00);
    rvalid = 1'b1;
    rdata  = 32'h1234_5678;
    tick();
    rvalid = 1'b0;
    check("busy_resp", {resp_valid, resp_err, resp_data, resp_tag},
          {1'b1, 1'b0, 32'h1234_5678, 4'h6});
    tick();

    // misaligned read: immediate error, no bus access
    send_req(1'b0, 32'h1000_0002, 4'h0, 32'h0, 4'h9);
    check("mis_resp_c1", {re, we, resp_valid, resp_err, resp_data, resp_tag},
          {1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 4'h9});
    tick();
    check("mis_done", {re, we, resp_valid}, 3'b000);

    // write with empty mask is still issued
    send_req(1'b1, 32'h0000_0008, 4'h0, 32'hAABB_CCDD, 4'hA);
    check("wm0_bus", {we, waddr, wmask, wdata}, {1'b1, 30'h2, 4'h0, 32'hAABB_CCDD});
    tick();
    check("wm0_resp", {resp_valid, resp_err, resp_data, resp_tag}, {1'b1, 1'b0, 32'h0, 4'hA});
    tick();

`ifdef MMIO_TIMEOUT_EN
    // no rvalid: error after TIMEOUT_CYC waiting cycles, later rvalid ignored
    resp_ready = 1'b0;
    send_req(1'b0, 32'h3000_0000, 4'h0, 32'h0, 4'hC);
    tick();
    for (int i = 0; i < TIMEOUT_CYC; i++) begin
      check($sformatf("tmo_wait_%0d", i), resp_valid, 0);
      tick();
    end
    check("tmo_resp", {resp_valid, resp_err, resp_data, resp_tag},
          {1'b1, 1'b1, 32'hFFFF_FFFF, 4'hC});
    rvalid = 1'b1;
    rdata  = 32'h0000_0055;
    tick();
    rvalid = 1'b0;
    check("tmo_late_rvalid", {resp_valid, resp_err, resp_data}, {1'b1, 1'b1, 32'hFFFF_FFFF});
    resp_ready = 1'b1;
    tick();
`endif

    // stalled response, then reset pulled mid-RESP
    resp_ready = 1'b0;
    send_req(1'b1, 32'h4000_0000, 4'hF, 32'hCAFE_F00D, 4'h7);
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_%0d", i), {resp_valid, resp_err, resp_data, resp_tag, req_ready},
            {1'b1, 1'b0, 32'h0, 4'h7, 1'b0});
      tick();
    end
    rst = 1'b0;
    #1;
    check("mid_rst_strobes", {re, we, resp_valid, resp_err, req_ready}, 5'b00000);
    check("mid_rst_data", {raddr, waddr, wmask, wdata, resp_data, resp_tag}, '0);
    tick();
    rst        = 1'b1;
    resp_ready = 1'b1;
    #1;
    check("post_rst_ready", {req_ready, resp_valid}, 2'b10);
    tick();
    check("post_rst_idle", {re, we, resp_valid, req_ready}, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_initiator.md
Name: mmio_initiator

Overview:
Bus initiator that drives the peripheral MMIO bus (re/raddr/rdata/rbusy/rvalid and we/wmask/waddr/wdata) on behalf of the load/store unit.
- Accepts one word-sized request at a time over a valid/ready handshake.
- Sequences the bus access, honours rbusy back-pressure and collects rvalid read data.
- Returns a tagged response upstream.
- Sits between the LSU MMIO path and the broadcast peripheral bus. rdata/rvalid/rbusy from the peripherals are OR-reduced outside this block.

Parameters:
TAG_W, 4, width of the request/response tag
TIMEOUT_CYC, 256, max cycles waiting for rvalid before an error response (used only with MMIO_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset (0 = in reset)
IN_req_valid  in  1  upstream request valid
OUT_req_ready  out  1  block can accept a request
IN_req_we  in  1  1 = write, 0 = read
IN_req_addr  in  32  byte address
IN_req_wmask  in  4  byte enables for writes
IN_req_wdata  in  32  write data
IN_req_tag  in  TAG_W  request tag
OUT_resp_valid  out  1  response valid
IN_resp_ready  in  1  upstream accepts response
OUT_resp_data  out  32  read data (0 for writes)
OUT_resp_err  out  1  misaligned access or timeout
OUT_resp_tag  out  TAG_W  tag of the completed request
OUT_re  out  1  bus read enable
OUT_raddr  out  30  word address
IN_rdata  in  32  bus read data
IN_rbusy  in  1  bus not accepting this cycle
IN_rvalid  in  1  bus read data valid
OUT_we  out  1  bus write enable
OUT_wmask  out  4  bus byte enables
OUT_waddr  out  30  word address
OUT_wdata  out  32  bus write data

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - FSM to IDLE.
  - OUT_re, OUT_we, OUT_resp_valid, OUT_resp_err, OUT_req_ready to 0.
  - All data, address, mask and tag outputs to 0.
- OUT_req_ready=1 only in IDLE with rst=1. A request is accepted when valid and ready are both 1; its fields are latched.
- FSM states:
  - IDLE → ISSUE on an aligned accept.
  - IDLE → RESP on a misaligned accept (addr[1:0]≠0). The response has err=1 and data=0, and no bus access is made.
  - ISSUE drives exactly one of OUT_re or OUT_we, with addr = req_addr[31:2].
    - IN_rbusy=1: stay in ISSUE and hold every bus output unchanged.
    - IN_rbusy=0, read: → WAIT_R.
    - IN_rbusy=0, write: → RESP with data=0, err=0. Writes have no acknowledge.
  - WAIT_R: OUT_re=0. On IN_rvalid=1, capture IN_rdata, err=0, → RESP.
  - RESP: OUT_resp_valid=1. Hold data, err and tag stable until IN_resp_ready=1, then → IDLE.
- OUT_re/OUT_we are registered. They are high only during ISSUE cycles and never high simultaneously.
- Minimum latency from accept (cycle 0):
  - Read: re at cycle 1, rvalid at cycle 2, resp_valid at cycle 3.
  - Write: we at cycle 1, resp_valid at cycle 2.
  - A response accepted at cycle N allows a new accept at cycle N+1.
- IN_rvalid is ignored in every state except WAIT_R. This covers rvalid in the ISSUE cycle and stray or late rvalid.
- OUT_wmask is driven from req_wmask for writes. A write with wmask=0 is still issued.
- Reset mid-operation: abort immediately, drop the pending response, and leave no bus strobe asserted.

Optional Feature:
MMIO_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT_R and increments each cycle there.
  - When it reaches TIMEOUT_CYC-1 without rvalid: → RESP with err=1, data=32'hFFFFFFFF.
  - If rvalid arrives in that same final cycle, rvalid wins (err=0).
- Undefined: WAIT_R waits indefinitely, no counter is instantiated, and err is asserted only on misalignment.

Decomposition:
- Package mmio_pkg holds:
  - State enum (IDLE, ISSUE, WAIT_R, RESP).
  - MmioReq_t struct (we, addr, wmask, wdata, tag).
  - MmioResp_t struct (data, err, tag).
  - Constant TIMEOUT_DATA = 32'hFFFFFFFF.
- No sub-module; the timeout counter is inline under the macro.

Test Plan:
- Write 0x00000055, wmask 4'b0001 to 0xFF000004 (IN_rbusy=0) → one cycle OUT_we=1, OUT_waddr=30'h3FC00001; resp_valid at cycle 2 with err=0, data=0, tag echoed.
- Read 0x10000000; responder returns rvalid with rdata=0xDEADBEEF one cycle after re → OUT_re pulses once with raddr=30'h04000000; resp at cycle 3, data=0xDEADBEEF, err=0.
- Read with IN_rbusy=1 for 3 cycles → OUT_re held high with stable raddr for 4 cycles; completes normally after rbusy drops.
- Read of 0x10000002 → no re/we ever asserted; resp_valid at cycle 1 with err=1, data=0.
- With MMIO_TIMEOUT_EN and TIMEOUT_CYC=8, read with no rvalid → resp err=1, data=0xFFFFFFFF after 8 WAIT_R cycles; a late rvalid afterwards is ignored.
- IN_resp_ready=0 for 5 cycles, then rst pulsed low mid-RESP → resp fields stable while stalled; after reset all outputs are 0 and ready=1 once rst=1.
